// File: rtl/csr_hpm.sv
// Machine counter / performance-monitor CSR bank: mcycle, minstret and CNT_NUM
// event counters with inhibit, sticky overflow flags and an overflow interrupt.
module csr_hpm #(
   parameter int CNT_NUM = 4,
   parameter int CNT_W   = 64,
   parameter int EVT_NUM = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               csr_we_i,
   input  logic [11:0]        csr_addr_i,
   input  logic [31:0]        csr_wdata_i,
   output logic [31:0]        csr_rdata_o,
   output logic               csr_hit_o,
   input  logic               retire_i,
   input  logic [EVT_NUM-1:0] evt_i,
   output logic               ovf_irq_o
);

   // Counter slot j sits at CSR offset 0 (mcycle), 2 (minstret) or j+1 (hpm j-2).
   localparam int NC = CNT_NUM + 2;
   localparam logic [31:0] IMPL_MASK = 32'h5 | 32'(((64'd1 << CNT_NUM) - 64'd1) << 3);
   localparam bit HAS_HI = (CNT_W > 32);

   logic [CNT_W-1:0] cnt_q [NC];
   logic [CNT_W-1:0] cnt_d [NC];
   logic [63:0]      cnt64 [NC];
   logic [4:0]       evt_q [CNT_NUM];
   logic [4:0]       evt_d [CNT_NUM];
   logic [31:0]      inh_q, inh_d;
   logic [31:0]      ovf_q, ovf_d;
   logic [31:0]      ovfie_q, ovfie_d;
   logic [NC-1:0]    inc_en, wr_lo, wr_hi, ovf_set;
   logic [31:0]      ovf_bits;

   function automatic int slot_off(input int j);
      return (j == 0) ? 0 : j + 1;
   endfunction

   // Selector 0 or above EVT_NUM matches no event input.
   function automatic logic evt_fire(input logic [4:0] sel, input logic [EVT_NUM-1:0] ev);
      logic f;
      f = 1'b0;
      for (int k = 0; k < EVT_NUM; k++)
         if (int'(sel) == k + 1) f = ev[k];
      return f;
   endfunction

   always_comb begin
      inc_en    = '0;
      inc_en[0] = ~inh_q[0];
      inc_en[1] = ~inh_q[2] & retire_i;
      for (int i = 0; i < CNT_NUM; i++)
         inc_en[2+i] = ~inh_q[3+i] & evt_fire(evt_q[i], evt_i);
   end

   always_comb begin
      for (int j = 0; j < NC; j++) begin
         cnt64[j] = 64'(cnt_q[j]);
         wr_lo[j] = csr_we_i && (csr_addr_i == 12'(32'hB00 + slot_off(j)));
         wr_hi[j] = HAS_HI && csr_we_i && (csr_addr_i == 12'(32'hB80 + slot_off(j)));
      end
   end

   // A CSR write to a counter overrides its increment and suppresses overflow.
   always_comb begin
      ovf_set = '0;
      for (int j = 0; j < NC; j++) begin
         cnt_d[j] = cnt_q[j];
         if (wr_lo[j]) begin
            cnt_d[j] = CNT_W'({cnt64[j][63:32], csr_wdata_i});
         end else if (wr_hi[j]) begin
            cnt_d[j] = CNT_W'({csr_wdata_i, cnt64[j][31:0]});
         end else if (inc_en[j]) begin
            cnt_d[j]   = cnt_q[j] + CNT_W'(1);
            ovf_set[j] = &cnt_q[j];
         end
      end
   end

   assign ovf_bits = 32'({ovf_set[NC-1:1], 1'b0, ovf_set[0]});

   always_comb begin
      inh_d   = inh_q;
      ovf_d   = ovf_q;
      ovfie_d = ovfie_q;
      for (int i = 0; i < CNT_NUM; i++) evt_d[i] = evt_q[i];
      if (csr_we_i) begin
         case (csr_addr_i)
            12'h320: inh_d   = csr_wdata_i & IMPL_MASK;
            12'h7C0: ovf_d   = ovf_q & ~csr_wdata_i;
            12'h7C1: ovfie_d = csr_wdata_i & IMPL_MASK;
            default: ;
         endcase
         for (int i = 0; i < CNT_NUM; i++)
            if (csr_addr_i == 12'(32'h323 + i)) evt_d[i] = csr_wdata_i[4:0];
      end
      // New overflow is OR-ed after the clear so a same-cycle set wins.
      ovf_d = (ovf_d | ovf_bits) & IMPL_MASK;
   end

   always_comb begin
      csr_rdata_o = '0;
      csr_hit_o   = 1'b0;
      for (int j = 0; j < NC; j++) begin
         if (csr_addr_i == 12'(32'hB00 + slot_off(j))) begin
            csr_hit_o   = 1'b1;
            csr_rdata_o = cnt64[j][31:0];
         end else if (csr_addr_i == 12'(32'hB80 + slot_off(j))) begin
            csr_hit_o   = 1'b1;
            csr_rdata_o = cnt64[j][63:32];
         end
      end
      for (int i = 0; i < CNT_NUM; i++) begin
         if (csr_addr_i == 12'(32'h323 + i)) begin
            csr_hit_o   = 1'b1;
            csr_rdata_o = {27'b0, evt_q[i]};
         end
      end
      case (csr_addr_i)
         12'h320: begin csr_hit_o = 1'b1; csr_rdata_o = inh_q;   end
         12'h7C0: begin csr_hit_o = 1'b1; csr_rdata_o = ovf_q;   end
         12'h7C1: begin csr_hit_o = 1'b1; csr_rdata_o = ovfie_q; end
         default: ;
      endcase
   end

   assign ovf_irq_o = |(ovf_q & ovfie_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < NC; j++) cnt_q[j] <= '0;
         for (int i = 0; i < CNT_NUM; i++) evt_q[i] <= '0;
         inh_q   <= '0;
         ovf_q   <= '0;
         ovfie_q <= '0;
      end else begin
         for (int j = 0; j < NC; j++) cnt_q[j] <= cnt_d[j];
         for (int i = 0; i < CNT_NUM; i++) evt_q[i] <= evt_d[i];
         inh_q   <= inh_d;
         ovf_q   <= ovf_d;
         ovfie_q <= ovfie_d;
      end
   end

endmodule

// File: tb/tb_csr_hpm.sv
// Bench for csr_hpm: directed scenarios plus random CSR/event traffic checked
// each cycle against a CSR-level reference model; a second small instance covers CNT_W=40.
module tb_csr_hpm;

   localparam int CNT_NUM = 4;
   localparam int CNT_W   = 64;
   localparam int EVT_NUM = 8;
   localparam int NCSR    = CNT_NUM + 3;
   localparam logic [63:0] W_MASK = (CNT_W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                  : ((64'd1 << CNT_W) - 64'd1);
   localparam logic [31:0] IMPL = 32'h5 | (((32'd1 << CNT_NUM) - 32'd1) << 3);
   localparam logic [11:0] POOL [24] = '{
      12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
      12'hB83, 12'hB84, 12'hB85, 12'hB86, 12'h323, 12'h324, 12'h325, 12'h326,
      12'h320, 12'h7C0, 12'h7C1, 12'hB01, 12'hB07, 12'h327, 12'hB81, 12'h321};

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic               csr_we_i = 1'b0;
   logic [11:0]        csr_addr_i = '0;
   logic [31:0]        csr_wdata_i = '0;
   logic [31:0]        csr_rdata_o;
   logic               csr_hit_o;
   logic               retire_i = 1'b0;
   logic [EVT_NUM-1:0] evt_i = '0;
   logic               ovf_irq_o;

   logic        s_rst = 1'b1;
   logic        s_we = 1'b0;
   logic [11:0] s_addr = '0;
   logic [31:0] s_wdata = '0;
   logic [31:0] s_rdata;
   logic        s_hit;
   logic        s_retire = 1'b0;
   logic [7:0]  s_evt = '0;
   logic        s_irq;

   csr_hpm #(.CNT_NUM(CNT_NUM), .CNT_W(CNT_W), .EVT_NUM(EVT_NUM)) u_dut (
      .clk(clk), .rst(rst), .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i),
      .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_hit_o(csr_hit_o),
      .retire_i(retire_i), .evt_i(evt_i), .ovf_irq_o(ovf_irq_o));

   csr_hpm #(.CNT_NUM(2), .CNT_W(40), .EVT_NUM(8)) u_small (
      .clk(clk), .rst(s_rst), .csr_we_i(s_we), .csr_addr_i(s_addr),
      .csr_wdata_i(s_wdata), .csr_rdata_o(s_rdata), .csr_hit_o(s_hit),
      .retire_i(s_retire), .evt_i(s_evt), .ovf_irq_o(s_irq));

   // reference model state, indexed by CSR counter number (1 unused)
   logic [63:0] m_cnt [NCSR];
   int          m_evt [CNT_NUM];
   logic [31:0] m_inh, m_ovf, m_ovfie;

   int n_vec = 0;
   int n_err = 0;

   logic [11:0] r_a;
   logic        r_we;
   logic [31:0] r_wd;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [11:0] a);
      logic [31:0] r;
      r = '0;
      for (int c = 0; c < NCSR; c++) begin
         if (c != 1) begin
            if (a == 12'(32'hB00 + c)) r = m_cnt[c][31:0];
            if (a == 12'(32'hB80 + c)) r = m_cnt[c][63:32];
         end
      end
      for (int i = 0; i < CNT_NUM; i++)
         if (a == 12'(32'h323 + i)) r = 32'(m_evt[i]);
      if (a == 12'h320) r = m_inh;
      if (a == 12'h7C0) r = m_ovf;
      if (a == 12'h7C1) r = m_ovfie;
      return r;
   endfunction

   function automatic logic m_hit(input logic [11:0] a);
      logic h;
      h = 1'b0;
      for (int c = 0; c < NCSR; c++)
         if (c != 1 && (a == 12'(32'hB00 + c) || a == 12'(32'hB80 + c))) h = 1'b1;
      for (int i = 0; i < CNT_NUM; i++)
         if (a == 12'(32'h323 + i)) h = 1'b1;
      if (a == 12'h320 || a == 12'h7C0 || a == 12'h7C1) h = 1'b1;
      return h;
   endfunction

   function automatic logic m_irq();
      return |(m_ovf & m_ovfie);
   endfunction

   // Advance the model by one clock edge given the inputs present before it.
   task automatic m_step(input logic r, input logic we, input logic [11:0] a,
                         input logic [31:0] wd, input logic ret, input logic [EVT_NUM-1:0] ev);
      logic [31:0] newovf;
      logic        counts;
      int          sel;
      if (r) begin
         for (int c = 0; c < NCSR; c++) m_cnt[c] = '0;
         for (int i = 0; i < CNT_NUM; i++) m_evt[i] = 0;
         m_inh = '0; m_ovf = '0; m_ovfie = '0;
      end else begin
         newovf = '0;
         for (int c = 0; c < NCSR; c++) begin
            if (c != 1) begin
               counts = 1'b0;
               if (!m_inh[c]) begin
                  if (c == 0) counts = 1'b1;
                  else if (c == 2) counts = ret;
                  else begin
                     sel = m_evt[c-3];
                     if (sel >= 1 && sel <= EVT_NUM) counts = ev[sel-1];
                  end
               end
               if (we && a == 12'(32'hB00 + c))
                  m_cnt[c] = {m_cnt[c][63:32], wd} & W_MASK;
               else if (we && a == 12'(32'hB80 + c) && CNT_W > 32)
                  m_cnt[c] = {wd, m_cnt[c][31:0]} & W_MASK;
               else if (counts) begin
                  if (m_cnt[c] == W_MASK) begin
                     m_cnt[c]  = '0;
                     newovf[c] = 1'b1;
                  end else begin
                     m_cnt[c] = m_cnt[c] + 64'd1;
                  end
               end
            end
         end
         if (we) begin
            if (a == 12'h320) m_inh = wd & IMPL;
            if (a == 12'h7C0) m_ovf = m_ovf & ~wd;
            if (a == 12'h7C1) m_ovfie = wd & IMPL;
            for (int i = 0; i < CNT_NUM; i++)
               if (a == 12'(32'h323 + i)) m_evt[i] = int'(wd[4:0]);
         end
         m_ovf = (m_ovf | newovf) & IMPL;
      end
   endtask

   // driver: one clock cycle of inputs, checking the pre-edge outputs
   task automatic cyc(input logic r, input logic we, input logic [11:0] a, input logic [31:0] wd,
                      input logic ret, input logic [EVT_NUM-1:0] ev, input string tag);
      @(negedge clk);
      rst = r; csr_we_i = we; csr_addr_i = a; csr_wdata_i = wd; retire_i = ret; evt_i = ev;
      #1;
      check({tag, "_rd"}, 64'(csr_rdata_o), 64'(m_read(a)));
      check({tag, "_hit"}, 64'(csr_hit_o), 64'(m_hit(a)));
      check({tag, "_irq"}, 64'(ovf_irq_o), 64'(m_irq()));
      m_step(r, we, a, wd, ret, ev);
   endtask

   initial begin
      m_step(1'b1, 1'b0, '0, '0, 1'b0, '0);

      // narrow instance: 40-bit counters, two hpm channels
      repeat (2) @(negedge clk);
      s_rst = 1'b0;
      @(negedge clk);
      s_we = 1'b1; s_addr = 12'hB84; s_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      s_we = 1'b0;
      #1 check("s_hi_rd", 64'(s_rdata), 64'hFF);
      check("s_hi_hit", 64'(s_hit), 64'd1);
      s_addr = 12'hB04;
      #1 check("s_lo_rd", 64'(s_rdata), 64'd0);
      s_addr = 12'hB05;
      #1 check("s_unimpl_rd", 64'(s_rdata), 64'd0);
      check("s_unimpl_hit", 64'(s_hit), 64'd0);
      s_addr = 12'hB85;
      #1 check("s_unimpl_hi_hit", 64'(s_hit), 64'd0);
      @(negedge clk);
      s_we = 1'b1; s_addr = 12'h7C1; s_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      s_we = 1'b0;
      #1 check("s_ovfie_mask", 64'(s_rdata), 64'h1D);
      check("s_irq", 64'(s_irq), 64'd0);

      // reset, then idle count
      cyc(1'b1, 1'b0, 12'hB00, '0, 1'b0, '0, "rst");
      repeat (10) cyc(1'b0, 1'b0, 12'hB00, '0, 1'b0, '0, "idle");
      cyc(1'b0, 1'b0, 12'hB00, '0, 1'b0, '0, "mcycle");
      check("mcycle_is10", 64'(csr_rdata_o), 64'd10);
      cyc(1'b0, 1'b0, 12'hB02, '0, 1'b0, '0, "minstret");
      check("minstret_is0", 64'(csr_rdata_o), 64'd0);
      cyc(1'b0, 1'b0, 12'hB03, '0, 1'b0, '0, "hpm3");
      check("hpm3_is0", 64'(csr_rdata_o), 64'd0);
      check("irq_idle", 64'(ovf_irq_o), 64'd0);

      // event select
      cyc(1'b0, 1'b1, 12'h323, 32'd2, 1'b0, '0, "sel2");
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b0, 12'hB03, '0, 1'b0, EVT_NUM'(2 | (k & 1)), "evt_on");
         cyc(1'b0, 1'b0, 12'hB03, '0, 1'b0, EVT_NUM'(~k & 1), "evt_off");
      end
      cyc(1'b0, 1'b0, 12'hB03, '0, 1'b0, '0, "hpm3_cnt");
      check("hpm3_is5", 64'(csr_rdata_o), 64'd5);
      cyc(1'b0, 1'b1, 12'h323, 32'd0, 1'b0, '0, "sel0");
      cyc(1'b0, 1'b0, 12'hB03, '0, 1'b0, EVT_NUM'(2), "sel0_evt");
      cyc(1'b0, 1'b0, 12'hB03, '0, 1'b0, '0, "sel0_rd");
      check("hpm3_sel0", 64'(csr_rdata_o), 64'd5);
      cyc(1'b0, 1'b1, 12'h323, 32'(EVT_NUM + 1), 1'b0, '0, "selbig");
      repeat (2) cyc(1'b0, 1'b0, 12'hB03, '0, 1'b0, '1, "selbig_evt");
      cyc(1'b0, 1'b0, 12'hB03, '0, 1'b0, '0, "selbig_rd");
      check("hpm3_selbig", 64'(csr_rdata_o), 64'd5);

      // mcycle wrap and interrupt
      cyc(1'b0, 1'b1, 12'hB80, 32'hFFFF_FFFF, 1'b0, '0, "mcycleh_wr");
      cyc(1'b0, 1'b1, 12'hB00, 32'hFFFF_FFFE, 1'b0, '0, "mcycle_wr");
      cyc(1'b0, 1'b1, 12'h7C1, 32'h1, 1'b0, '0, "ovfie_wr");
      cyc(1'b0, 1'b0, 12'hB00, '0, 1'b0, '0, "wrap_edge");
      cyc(1'b0, 1'b0, 12'hB00, '0, 1'b0, '0, "wrapped");
      check("mcycle_wrapped", 64'(csr_rdata_o), 64'd0);
      check("irq_set", 64'(ovf_irq_o), 64'd1);
      cyc(1'b0, 1'b1, 12'h7C0, 32'h1, 1'b0, '0, "w1c");
      cyc(1'b0, 1'b0, 12'h7C0, '0, 1'b0, '0, "after_w1c");
      check("irq_cleared", 64'(ovf_irq_o), 64'd0);

      // minstret inhibit
      cyc(1'b0, 1'b1, 12'h320, 32'h4, 1'b1, '0, "inh_wr");
      repeat (20) cyc(1'b0, 1'b0, 12'hB02, '0, 1'b1, '0, "inh_hold");
      cyc(1'b0, 1'b1, 12'h320, 32'h0, 1'b1, '0, "inh_clr");
      repeat (5) cyc(1'b0, 1'b0, 12'hB02, '0, 1'b1, '0, "inh_resume");

      // same-cycle collisions
      cyc(1'b0, 1'b1, 12'h323, 32'd2, 1'b0, '0, "sel2b");
      cyc(1'b0, 1'b1, 12'hB03, 32'h100, 1'b0, EVT_NUM'(2), "wr_vs_evt");
      cyc(1'b0, 1'b0, 12'hB03, '0, 1'b0, '0, "wr_wins");
      check("write_wins", 64'(csr_rdata_o), 64'h100);
      cyc(1'b0, 1'b1, 12'hB83, 32'hFFFF_FFFF, 1'b0, '0, "hpm3h_wr");
      cyc(1'b0, 1'b1, 12'hB03, 32'hFFFF_FFFF, 1'b0, '0, "hpm3l_wr");
      cyc(1'b0, 1'b1, 12'h7C0, 32'h8, 1'b0, EVT_NUM'(2), "w1c_vs_wrap");
      cyc(1'b0, 1'b0, 12'h7C0, '0, 1'b0, '0, "set_wins");
      check("set_wins", 64'(csr_rdata_o[3]), 64'd1);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         r_a  = POOL[$urandom_range(0, 23)];
         r_we = ($urandom_range(0, 5) == 0);
         r_wd = $urandom;
         if (r_a >= 12'h321 && r_a <= 12'h327)
            r_wd = 32'($urandom_range(0, 10)) | ($urandom & 32'hFFFF_FFE0);
         else if (r_a == 12'h320)
            r_wd = $urandom & $urandom & $urandom;
         else if ($urandom_range(0, 1) == 1)
            r_wd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         cyc(1'b0, r_we, r_a, r_wd, 1'($urandom_range(0, 1)), EVT_NUM'($urandom), "rand");
      end

      // reset mid-count with activity on every input
      s_rst = 1'b1;
      cyc(1'b1, 1'b1, 12'hB03, $urandom, 1'b1, '1, "rst_mid");
      for (int k = 0; k < 24; k++) begin
         cyc(1'b1, 1'b0, POOL[k], '0, 1'b1, '1, "post_rst");
         check("post_rst_zero", 64'(csr_rdata_o), 64'd0);
      end
      s_addr = 12'hB84;
      #1 check("s_post_rst", 64'(s_rdata), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/csr_hpm.md
Name: csr_hpm

Overview:
- Parametrised machine counter/performance-monitor CSR bank that generalises the core's fixed mcycle/minstret counters.
- Adds CNT_NUM programmable mhpmcounter channels with event select, per-counter inhibit, sticky overflow flags and a maskable overflow interrupt.
- Sits beside the core CSR file on the idex CSR access channel. The core CSR file forwards counter-range addresses here and muxes csr_rdata_o into its read path.

Parameters:
CNT_NUM, 4, number of hpm counters (1..29); counter i is mhpmcounter(3+i).
CNT_W, 64, width of every counter including mcycle/minstret (32..64).
EVT_NUM, 8, number of event inputs (1..31).

Ports:
clk  in  1  core clock; one clock; all state updates on its rising edge.
rst  in  1  reset, synchronous and active-high.
csr_we_i  in  1  CSR write strobe, single cycle.
csr_addr_i  in  12  CSR address.
csr_wdata_i  in  32  write data (final value, already RW/RS/RC-resolved).
csr_rdata_o  out  32  read data, combinational from csr_addr_i.
csr_hit_o  out  1  combinational; 1 when csr_addr_i is implemented here.
retire_i  in  1  instruction retired this cycle (hx_valid).
evt_i  in  EVT_NUM  event pulses, one count per cycle high.
ovf_irq_o  out  1  |(ovf & ovfie); feeds the mip/trap logic as a local interrupt.

Behaviour:
- Address map:
  - mcycle 0xB00 / mcycleh 0xB80.
  - minstret 0xB02 / minstreth 0xB82.
  - mhpmcounter(3+i) at 0xB03+i / 0xB83+i.
  - mhpmevent(3+i) at 0x323+i.
  - mcountinhibit 0x320.
  - mcntovf 0x7C0 (custom).
  - mcntovfie 0x7C1 (custom).
  - Any other address: csr_hit_o=0, csr_rdata_o=0, writes ignored.
- Reset (rst=1 at clk edge): all counters 0, mhpmevent 0, mcountinhibit 0, mcntovf 0, mcntovfie 0. Hence ovf_irq_o=0.
- Counter enables, evaluated each cycle:
  - mcycle increments when inhibit[0]=0.
  - minstret increments when inhibit[2]=0 and retire_i=1.
  - hpm i increments when inhibit[3+i]=0, sel=mhpmevent_i[4:0], 1<=sel<=EVT_NUM and evt_i[sel-1]=1.
  - sel=0 or sel>EVT_NUM: never counts.
- Increment is +1 modulo 2^CNT_W. The all-ones -> 0 wrap sets the sticky flag on the same edge, visible the next cycle:
  - mcntovf[0] for mcycle, [2] for minstret, [3+i] for hpm i.
- Write access:
  - Low half write replaces counter[31:0] and keeps the upper bits.
  - High half write replaces counter[CNT_W-1:32].
  - The written counter does not increment that cycle (write wins), and no overflow is flagged that cycle.
  - CNT_W=32: high-half addresses are implemented, read 0, writes ignored.
- Read access:
  - High half reads counter[CNT_W-1:32] zero-extended to 32.
  - Reads return the pre-edge value (no bypass of same-cycle writes).
- mhpmevent: bits[4:0] stored, other bits read 0.
- mcountinhibit: bit0, bit2 and bits[3+CNT_NUM-1:3] are writable; all other bits read 0.
- mcntovf:
  - Write-1-to-clear; writing 0 has no effect.
  - If a W1C and a new overflow hit the same bit in the same cycle, set wins.
  - Unimplemented bits read 0.
- mcntovfie: plain RW on the same implemented bit positions.
- ovf_irq_o: combinational from registers, so the interrupt asserts one cycle after the overflowing edge.
- No state machine beyond counters; every CSR op completes in one cycle. There is no stall or handshake.
- Reset asserted mid-count clears everything on that edge, with no partial update.

Test Plan:
- Reset, then 10 idle cycles, inhibit=0 -> mcycle reads 10 (±1 per read timing), minstret 0, all hpm 0, ovf_irq_o=0.
- Write mhpmevent3=2 and pulse evt_i[1] 5 times while evt_i[0] toggles -> mhpmcounter3=5. Then write mhpmevent3=0 and pulse evt_i[1] -> stays 5. Then write mhpmevent3=EVT_NUM+1 -> stays 5.
- CNT_W=64: write mcycleh=0xFFFFFFFF and mcycle=0xFFFFFFFE, mcntovfie=1 -> counter wraps to 0 two cycles later, mcntovf[0]=1, ovf_irq_o=1 the next cycle. Write mcntovf=1 -> ovf_irq_o=0.
- Write mcountinhibit=0x4 with retire_i held high 20 cycles -> minstret unchanged while mcycle advances. Write inhibit=0 -> minstret resumes +1 per cycle.
- Same-cycle collisions:
  - Write mhpmcounter3=0x100 while its event fires -> reads 0x100, not 0x101.
  - W1C mcntovf[3] on the cycle counter3 wraps -> flag stays 1.
- CNT_W=40, CNT_NUM=2: write 0xB84=0xFFFFFFFF -> reads 0x000000FF. Read address 0xB05 -> csr_hit_o=0 and rdata=0. Assert rst mid-count -> every readback is 0 on the next cycle.
